fe_ifu: RTL and testbench

- Instruction fetch unit: the producer end of the IF/ID interface that the decode stage consumes.
- Owns the PC and the instruction-memory read port.
- Delivers instruction, PC, next-PC and valid to decode.
- Honours decode hold, and redirects on decode-resolved jal/jalr and execute-resolved taken branches.
- Drives the decode flush line when an older redirect invalidates the instruction currently in decode.

---
 rtl/fe_ifu.sv | 129 ++++++++++++
 tb/tb_fe_ifu.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fe_ifu.sv
// Instruction fetch unit: owns the PC and imem read port and feeds IF/ID.
// Redirects come from decode (jal/jalr) and execute (taken branch).
module fe_ifu #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_hold,
  input  logic        i_jal,
  input  logic        i_jalr,
  input  logic [31:0] i_immediate,
  input  logic [31:0] i_jalr_rs1,
  input  logic        i_br_taken,
  input  logic [31:0] i_br_target,
  input  logic        i_halt,
  output logic [31:0] o_imem_raddr,
  output logic        o_imem_ren,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_inst,
  output logic        o_vld,
  output logic [31:0] o_pc,
  output logic [31:0] o_nxt_pc,
  output logic        o_flush,
  output logic        o_misalign
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_HALT
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc_f;
  logic [31:0] pc_f_nxt;
  logic [31:0] pc_d;
  logic [31:0] pc_d_nxt;
  logic        vld_d;
  logic        vld_d_nxt;
  logic [31:0] raddr;
  logic        ren;
  logic [31:0] jal_tgt;
  logic [31:0] jalr_sum;
  logic [31:0] jalr_tgt;
  logic        flush;
  logic        vld;

  assign jal_tgt  = pc_d + i_immediate;
  assign jalr_sum = i_jalr_rs1 + i_immediate;
  assign jalr_tgt = jalr_sum & ~32'd1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_BOOT;
      pc_f  <= RESET_ADDR;
      pc_d  <= RESET_ADDR;
      vld_d <= 1'b0;
    end else begin
      state <= state_nxt;
      pc_f  <= pc_f_nxt;
      pc_d  <= pc_d_nxt;
      vld_d <= vld_d_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_f_nxt  = pc_f;
    pc_d_nxt  = pc_d;
    vld_d_nxt = vld_d;
    raddr     = pc_d;
    ren       = 1'b0;
    unique case (state)
      S_BOOT: begin
        raddr     = RESET_ADDR;
        ren       = 1'b1;
        pc_d_nxt  = RESET_ADDR;
        pc_f_nxt  = RESET_ADDR + 32'd4;
        vld_d_nxt = 1'b1;
        state_nxt = S_RUN;
      end
      S_RUN: begin
        if (i_halt) begin
          state_nxt = S_HALT;
          vld_d_nxt = 1'b0;
        end else begin
          ren       = 1'b1;
          vld_d_nxt = 1'b1;
          // hold re-reads pc_d so the instruction in decode stays stable
          if (i_br_taken) begin
            raddr = i_br_target;
          end else if (i_jal && !i_hold) begin
            raddr = jal_tgt;
          end else if (i_jalr && !i_hold) begin
            raddr = jalr_tgt;
          end else if (i_hold) begin
            raddr = pc_d;
          end else begin
            raddr = pc_f;
          end
          if (i_br_taken || !i_hold) begin
            pc_d_nxt = raddr;
            pc_f_nxt = raddr + 32'd4;
          end
        end
      end
      S_HALT: begin
        ren = 1'b0;
      end
      default: begin
        state_nxt = S_BOOT;
      end
    endcase
  end

  assign flush = i_br_taken && (state == S_RUN) && !i_rst;
  assign vld   = vld_d && !flush && (state != S_HALT) && !i_rst;

  assign o_imem_raddr = raddr;
  assign o_imem_ren   = ren && !i_rst;
  assign o_inst       = i_imem_rdata;
  assign o_vld        = vld;
  assign o_pc         = pc_d;
  assign o_nxt_pc     = pc_d + 32'd4;
  assign o_flush      = flush;
  assign o_misalign   = vld && (pc_d[1:0] != 2'b00);

endmodule

// File: tb/tb_fe_ifu.sv
// Directed bench for fe_ifu: boot, hold, jal/jalr, branch priority,
// misalign, PC wrap, halt and re-boot, against an imem where imem[x]=x.
module tb_fe_ifu;

  logic        clk;
  logic        rst;
  logic        hold;
  logic        jal;
  logic        jalr;
  logic [31:0] imm;
  logic [31:0] rs1;
  logic        br_taken;
  logic [31:0] br_target;
  logic        halt;
  logic [31:0] raddr;
  logic        ren;
  logic [31:0] rdata;
  logic [31:0] inst;
  logic        vld;
  logic [31:0] pc;
  logic [31:0] nxt_pc;
  logic        flush;
  logic        misalign;

  int n_eval;
  int n_fail;

  fe_ifu #(.RESET_ADDR(32'h0000_0100)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_hold       (hold),
    .i_jal        (jal),
    .i_jalr       (jalr),
    .i_immediate  (imm),
    .i_jalr_rs1   (rs1),
    .i_br_taken   (br_taken),
    .i_br_target  (br_target),
    .i_halt       (halt),
    .o_imem_raddr (raddr),
    .o_imem_ren   (ren),
    .i_imem_rdata (rdata),
    .o_inst       (inst),
    .o_vld        (vld),
    .o_pc         (pc),
    .o_nxt_pc     (nxt_pc),
    .o_flush      (flush),
    .o_misalign   (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // imem with 1-cycle latency whose contents equal the address
  always @(posedge clk) begin
    if (ren) rdata <= raddr;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_eval++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_eval    = 0;
    n_fail    = 0;
    rst       = 1'b1;
    hold      = 1'b0;
    jal       = 1'b0;
    jalr      = 1'b0;
    imm       = 32'h0;
    rs1       = 32'h0;
    br_taken  = 1'b1;
    br_target = 32'h0;
    halt      = 1'b0;
    rdata     = 32'h0;
    tick();
    tick();
    #1;
    chk("rst_vld", {31'd0, vld}, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_ren", {31'd0, ren}, 32'd0);
    chk("rst_mis", {31'd0, misalign}, 32'd0);
    br_taken = 1'b0;
    rst = 1'b0;
    #1;
    chk("boot_raddr", raddr, 32'h100);
    chk("boot_ren", {31'd0, ren}, 32'd1);
    chk("boot_vld", {31'd0, vld}, 32'd0);
    tick();
    #1;
    chk("run_vld", {31'd0, vld}, 32'd1);
    chk("run_pc", pc, 32'h100);
    chk("run_nxt", nxt_pc, 32'h104);
    chk("run_inst", inst, 32'h100);
    chk("run_raddr", raddr, 32'h104);
    tick();
    hold = 1'b1;
    #1;
    chk("hold1_raddr", raddr, 32'h104);
    chk("hold1_pc", pc, 32'h104);
    chk("hold1_inst", inst, 32'h104);
    tick();
    #1;
    chk("hold2_raddr", raddr, 32'h104);
    chk("hold2_pc", pc, 32'h104);
    chk("hold2_inst", inst, 32'h104);
    hold = 1'b0;
    #1;
    chk("unhold_raddr", raddr, 32'h108);
    tick();
    jal = 1'b1;
    imm = 32'h20;
    #1;
    chk("jal_pc", pc, 32'h108);
    chk("jal_raddr", raddr, 32'h128);
    chk("jal_flush", {31'd0, flush}, 32'd0);
    chk("jal_vld", {31'd0, vld}, 32'd1);
    tick();
    jal = 1'b0;
    jalr = 1'b1;
    rs1 = 32'h201;
    imm = 32'h0;
    #1;
    chk("jal_dst_pc", pc, 32'h128);
    chk("jal_dst_inst", inst, 32'h128);
    chk("jalr_raddr", raddr, 32'h200);
    tick();
    rs1 = 32'h231;
    imm = 32'h10;
    hold = 1'b1;
    #1;
    chk("jalr_dst_pc", pc, 32'h200);
    chk("jalr_hold_raddr", raddr, 32'h200);
    tick();
    #1;
    chk("jalr_hold2_pc", pc, 32'h200);
    hold = 1'b0;
    #1;
    chk("jalr_rel_raddr", raddr, 32'h240);
    tick();
    jalr = 1'b0;
    br_taken = 1'b1;
    br_target = 32'h300;
    jal = 1'b1;
    hold = 1'b1;
    imm = 32'h20;
    #1;
    chk("br_pc", pc, 32'h240);
    chk("br_raddr", raddr, 32'h300);
    chk("br_flush", {31'd0, flush}, 32'd1);
    chk("br_vld", {31'd0, vld}, 32'd0);
    tick();
    jal = 1'b0;
    hold = 1'b0;
    br_target = 32'h302;
    #1;
    chk("br_dst_pc", pc, 32'h300);
    chk("br_dst_inst", inst, 32'h300);
    tick();
    br_taken = 1'b0;
    #1;
    chk("mis_pc", pc, 32'h302);
    chk("mis_flag", {31'd0, misalign}, 32'd1);
    chk("mis_nxt", nxt_pc, 32'h306);
    chk("mis_raddr", raddr, 32'h306);
    br_taken = 1'b1;
    br_target = 32'hFFFF_FFFC;
    #1;
    chk("mis_flush_vld", {31'd0, vld}, 32'd0);
    chk("mis_flush_mis", {31'd0, misalign}, 32'd0);
    tick();
    br_taken = 1'b0;
    #1;
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_nxt", nxt_pc, 32'h0);
    chk("wrap_raddr", raddr, 32'h0);
    tick();
    #1;
    chk("wrap_dst_pc", pc, 32'h0);
    chk("wrap_dst_inst", inst, 32'h0);
    halt = 1'b1;
    br_taken = 1'b1;
    br_target = 32'h500;
    #1;
    chk("halt_ren", {31'd0, ren}, 32'd0);
    chk("halt_flush", {31'd0, flush}, 32'd1);
    tick();
    halt = 1'b0;
    #1;
    chk("halted_flush", {31'd0, flush}, 32'd0);
    br_taken = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("halted_ren", {31'd0, ren}, 32'd0);
      chk("halted_vld", {31'd0, vld}, 32'd0);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("reboot_raddr", raddr, 32'h100);
    chk("reboot_ren", {31'd0, ren}, 32'd1);
    chk("reboot_vld", {31'd0, vld}, 32'd0);
    tick();
    #1;
    chk("reboot_run_vld", {31'd0, vld}, 32'd1);
    chk("reboot_run_pc", pc, 32'h100);
    chk("reboot_run_inst", inst, 32'h100);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_eval, n_fail);
    $finish;
  end

endmodule
